// File: rtl/apb_mem_slave_ws_pkg.sv
// Shared types and helpers for the APB memory slave with wait states.
// Contents:
//   state_e      - slave FSM states (IDLE, ACCESS)
//   err_cause_e  - reason a transfer is answered with slv_err
//   BYTES/IDX_LSB for the default 32-bit data width, plus helper functions
//   that compute the same values for any supported width.
package apb_mem_slave_ws_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Kept as a distinct cause rather than one bit so coverage and
  // debug can tell the three error classes apart.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_RO    = 2'd3
  } err_cause_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES          = DEF_DATA_WIDTH / 8;
  localparam int IDX_LSB        = $clog2(BYTES);

  // Number of byte lanes in a word of the given width.
  function automatic int bytesOf(input int dataWidth);
    return dataWidth / 8;
  endfunction

  // Number of low address bits that select a byte within a word.
  function automatic int idxLsbOf(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_ws_if.sv
// APB bus bundle between one master and the memory slave.
// Ports (signals):
//   sel, enable, write, addr, wdata, strb  - driven by the master
//   rdata, ready, slv_err                  - driven by the slave
// Modports: master, slave.
interface apb_mem_slave_ws_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                      sel;
  logic                      enable;
  logic                      write;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   strb;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      ready;
  logic                      slv_err;

  modport master (
    output sel, enable, write, addr, wdata, strb,
    input  rdata, ready, slv_err
  );

  modport slave (
    input  sel, enable, write, addr, wdata, strb,
    output rdata, ready, slv_err
  );

endinterface

// File: rtl/apb_mem_slave_ws_array.sv
// Word-organised storage for the APB memory slave.
// Ports:
//   clk_i    - clock
//   we_i     - write enable, qualified per byte by be_i
//   be_i     - byte-lane enables
//   waddr_i  - write word index
//   wdata_i  - write data
//   re_i     - read enable; rdata_o updates only when set
//   raddr_i  - read word index
//   rdata_o  - registered read data
// Contents are never reset so the array maps onto plain RAM.
module apb_mem_slave_ws_array
  import apb_mem_slave_ws_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                            clk_i,
  input  logic                            we_i,
  input  logic [bytesOf(DATA_WIDTH)-1:0]  be_i,
  input  logic [ADDR_W-1:0]               waddr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic                            re_i,
  input  logic [ADDR_W-1:0]               raddr_i,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  localparam int NumBytes = bytesOf(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane write and synchronous read share one clocked block so the
  // storage infers as a single-clock RAM with per-byte write enables.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB memory slave with configurable wait states, byte strobes, a
// read-only low region and error responses.
// Ports:
//   clk_i      - clock, all logic on the rising edge
//   reset_n_i  - synchronous active-low reset
//   bus        - APB slave modport (sel, enable, write, addr, wdata, strb
//                in; rdata, ready, slv_err out)
// ready, slv_err and rdata all come straight from registers.
module apb_mem_slave_ws
  import apb_mem_slave_ws_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2,
  parameter int RO_WORDS    = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  apb_mem_slave_ws_if.slave  bus
);

  localparam int NumBytes = bytesOf(DATA_WIDTH);
  localparam int IdxLsb   = idxLsbOf(DATA_WIDTH);
  localparam int MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(NumBytes - 1);

  state_e                 state_q;
  logic                   ready_q;
  logic                   slvErr_q;
  logic                   rdValid_q;
  logic [3:0]             waitCnt_q;
  logic                   write_q;
  logic [MemAw-1:0]       idx_q;
  err_cause_e             cause_q;

  logic [ADDR_WIDTH-1:0]  setupIdx;
  err_cause_e             setupCause;
  logic                   setupSeen;
  logic                   loadNow_d;
  logic                   loadWrite_d;
  logic                   loadErr_d;
  logic [MemAw-1:0]       loadIdx_d;
  logic                   readEn;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  arrayRdata;

  // Classify the address presented during setup. Reads are never
  // blocked by the read-only region, only writes.
  always_comb begin
    setupIdx   = bus.addr >> IdxLsb;
    setupCause = ERR_NONE;
    if ((bus.addr & AlignMask) != '0) begin
      setupCause = ERR_ALIGN;
    end else if (int'(setupIdx) >= DEPTH) begin
      setupCause = ERR_RANGE;
    end else if (bus.write && (int'(setupIdx) < RO_WORDS)) begin
      setupCause = ERR_RO;
    end
  end

  // The response is loaded either on the setup edge (no wait states) or
  // when the counter expires; in the first case the latched copies are
  // not yet valid, so the live setup values are used instead.
  always_comb begin
    setupSeen   = (state_q == IDLE) && bus.sel && !bus.enable;
    loadNow_d   = (setupSeen && (WAIT_STATES == 0)) ||
                  ((state_q == ACCESS) && bus.sel && !ready_q && (waitCnt_q == 4'd1));
    loadWrite_d = (state_q == IDLE) ? bus.write : write_q;
    loadErr_d   = ((state_q == IDLE) ? setupCause : cause_q) != ERR_NONE;
    loadIdx_d   = (state_q == IDLE) ? setupIdx[MemAw-1:0] : idx_q;
    readEn      = loadNow_d && !loadWrite_d && !loadErr_d;
    // Gating with reset_n_i keeps a reset on the completion edge from
    // committing the write.
    commit      = (state_q == ACCESS) && bus.sel && bus.enable && ready_q &&
                  write_q && (cause_q == ERR_NONE) && reset_n_i;
  end

  // Transfer FSM: latches the setup, counts wait states, raises ready
  // with the response, and returns to IDLE on completion or abort.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      slvErr_q  <= 1'b0;
      rdValid_q <= 1'b0;
      waitCnt_q <= 4'd0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      cause_q   <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (setupSeen) begin
            write_q   <= bus.write;
            idx_q     <= setupIdx[MemAw-1:0];
            cause_q   <= setupCause;
            waitCnt_q <= 4'(WAIT_STATES);
            state_q   <= ACCESS;
            if (WAIT_STATES == 0) begin
              ready_q   <= 1'b1;
              slvErr_q  <= loadErr_d;
              rdValid_q <= loadWrite_d ? rdValid_q : !loadErr_d;
            end
          end
        end
        ACCESS: begin
          if (!bus.sel) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            slvErr_q  <= 1'b0;
            rdValid_q <= 1'b0;
            waitCnt_q <= 4'd0;
          end else if (ready_q) begin
            if (bus.enable) begin
              state_q   <= IDLE;
              ready_q   <= 1'b0;
              slvErr_q  <= 1'b0;
              rdValid_q <= 1'b0;
            end
          end else if (waitCnt_q > 4'd1) begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end else if (waitCnt_q == 4'd1) begin
            waitCnt_q <= 4'd0;
            ready_q   <= 1'b1;
            slvErr_q  <= loadErr_d;
            rdValid_q <= loadWrite_d ? rdValid_q : !loadErr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_mem_slave_ws_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (MemAw)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (commit),
    .be_i    (bus.strb),
    .waddr_i (idx_q),
    .wdata_i (bus.wdata),
    .re_i    (readEn),
    .raddr_i (loadIdx_d),
    .rdata_o (arrayRdata)
  );

  // rdata is zero except while a successful read response is on the bus.
  assign bus.ready   = ready_q;
  assign bus.slv_err = slvErr_q;
  assign bus.rdata   = rdValid_q ? arrayRdata : '0;

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Testbench for apb_mem_slave_ws. Two instances are exercised:
//   unit 0: DEPTH=512, WAIT_STATES=2, RO_WORDS=4
//   unit 1: DEPTH=1024, WAIT_STATES=0, RO_WORDS=0
// A reference memory model predicts every response; monitors pop the
// predictions whenever a transfer completes on the bus.
module tb_apb_mem_slave_ws;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        err;
    bit          dataKnown;
  } exp_t;

  logic clk;
  logic resetA_n;
  logic resetB_n;

  apb_mem_slave_ws_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) busA ();
  apb_mem_slave_ws_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) busB ();

  apb_mem_slave_ws #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(WS_A), .RO_WORDS(4)
  ) dutA (
    .clk_i     (clk),
    .reset_n_i (resetA_n),
    .bus       (busA)
  );

  apb_mem_slave_ws #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(WS_B), .RO_WORDS(0)
  ) dutB (
    .clk_i     (clk),
    .reset_n_i (resetB_n),
    .bus       (busB)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t qA[$];
  exp_t qB[$];
  int   accCnt[2];
  bit   scoreEn[2];

  logic [31:0] modelMem [2][1024];
  logic [3:0]  modelKnown [2][1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a hung handshake still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int depthOf(input int unit);
    return (unit == 0) ? 512 : 1024;
  endfunction

  function automatic int roOf(input int unit);
    return (unit == 0) ? 4 : 0;
  endfunction

  function automatic int wsOf(input int unit);
    return (unit == 0) ? WS_A : WS_B;
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: applies the access rules to a plain word array and
  // returns the response the slave must give.
  function automatic exp_t modelAccess(input int unit, input logic wr, input logic [11:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb);
    exp_t e;
    int   idx;
    bit   mis;
    idx = int'(addr) / 4;
    mis = (int'(addr) % 4) != 0;
    e.addr      = addr;
    e.err       = mis || (idx >= depthOf(unit)) || (wr && (idx < roOf(unit)));
    e.rdata     = 32'h0;
    e.dataKnown = 1'b1;
    if (wr) begin
      if (!e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            modelMem[unit][idx][b*8 +: 8] = wdata[b*8 +: 8];
            modelKnown[unit][idx][b] = 1'b1;
          end
        end
      end
    end else if (!e.err) begin
      e.rdata     = modelMem[unit][idx];
      e.dataKnown = (modelKnown[unit][idx] == 4'hF);
    end
    return e;
  endfunction

  task automatic setCtrl(input int unit, input logic sel, input logic en);
    if (unit == 0) begin busA.sel = sel; busA.enable = en; end
    else begin busB.sel = sel; busB.enable = en; end
  endtask

  task automatic setWrAddr(input int unit, input logic wr, input logic [11:0] addr);
    if (unit == 0) begin busA.write = wr; busA.addr = addr; end
    else begin busB.write = wr; busB.addr = addr; end
  endtask

  task automatic setData(input int unit, input logic [31:0] wdata, input logic [3:0] strb);
    if (unit == 0) begin busA.wdata = wdata; busA.strb = strb; end
    else begin busB.wdata = wdata; busB.strb = strb; end
  endtask

  function automatic logic readyOf(input int unit);
    return (unit == 0) ? busA.ready : busB.ready;
  endfunction

  function automatic logic errOf(input int unit);
    return (unit == 0) ? busA.slv_err : busB.slv_err;
  endfunction

  function automatic logic [31:0] rdataOf(input int unit);
    return (unit == 0) ? busA.rdata : busB.rdata;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits in the access phase for ready; optionally disturbs addr/write,
  // which the slave must ignore once the setup is latched.
  task automatic waitReady(input int unit, input bit scramble, output bit done);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (readyOf(unit)) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (scramble) setWrAddr(unit, 1'($urandom), 12'($urandom_range(0, 4095)));
    end
    if (!done) checkOutput($sformatf("u%0d ready timeout", unit), 64'd0, 64'd1);
  endtask

  // Issues one complete transfer starting at posedge+1 and returns at
  // posedge+1 after the completion edge, so calls chain back-to-back.
  task automatic applyStimulus(input int unit, input logic wr, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input bit scramble);
    exp_t e;
    bit   done;
    e = modelAccess(unit, wr, addr, wdata, strb);
    if (unit == 0) qA.push_back(e); else qB.push_back(e);
    setWrAddr(unit, wr, addr);
    setData(unit, wdata, strb);
    setCtrl(unit, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    setCtrl(unit, 1'b1, 1'b1);
    waitReady(unit, scramble, done);
    @(posedge clk);
    #1;
    setCtrl(unit, 1'b0, 1'b0);
  endtask

  // Counts access cycles and scores each completed transfer against the
  // oldest outstanding prediction.
  task automatic monitorUnit(input int unit, input logic sel, input logic en, input logic rdy,
                             input logic err, input logic [31:0] rd);
    exp_t e;
    bit   have;
    if (sel && !en) accCnt[unit] = 0;
    else if (sel && en) accCnt[unit]++;
    if (sel && en && rdy && scoreEn[unit]) begin
      have = 1'b0;
      if (unit == 0) begin
        if (qA.size() > 0) begin e = qA.pop_front(); have = 1'b1; end
      end else begin
        if (qB.size() > 0) begin e = qB.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        checkOutput($sformatf("u%0d unexpected response", unit), 64'd1, 64'd0);
      end else begin
        checkOutput($sformatf("u%0d slv_err addr=%h", unit, e.addr), 64'(err), 64'(e.err));
        if (e.dataKnown) checkOutput($sformatf("u%0d rdata addr=%h", unit, e.addr), 64'(rd), 64'(e.rdata));
        checkOutput($sformatf("u%0d access cycles addr=%h", unit, e.addr), 64'(accCnt[unit]), 64'(wsOf(unit) + 1));
      end
    end
  endtask

  always @(negedge clk) monitorUnit(0, busA.sel, busA.enable, busA.ready, busA.slv_err, busA.rdata);
  always @(negedge clk) monitorUnit(1, busB.sel, busB.enable, busB.ready, busB.slv_err, busB.rdata);

  initial begin
    bit done;
    for (int u = 0; u < 2; u++) begin
      accCnt[u]  = 0;
      scoreEn[u] = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        modelMem[u][i]   = 32'h0;
        modelKnown[u][i] = 4'h0;
      end
      setCtrl(u, 1'b0, 1'b0);
      setWrAddr(u, 1'b0, 12'h0);
      setData(u, 32'h0, 4'h0);
    end
    resetA_n = 1'b0;
    resetB_n = 1'b0;
    idle(3);
    $display("[TB] reset state");
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d reset ready", u), 64'(readyOf(u)), 64'd0);
      checkOutput($sformatf("u%0d reset slv_err", u), 64'(errOf(u)), 64'd0);
      checkOutput($sformatf("u%0d reset rdata", u), 64'(rdataOf(u)), 64'd0);
    end
    resetA_n = 1'b1;
    resetB_n = 1'b1;
    idle(1);

    $display("[TB] enable without setup is ignored");
    for (int u = 0; u < 2; u++) begin
      setWrAddr(u, 1'b0, 12'h010);
      setCtrl(u, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput($sformatf("u%0d idle enable ready", u), 64'(readyOf(u)), 64'd0);
        @(posedge clk);
        #1;
      end
      setCtrl(u, 1'b0, 1'b0);
      idle(1);
    end

    $display("[TB] directed writes/reads");
    applyStimulus(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 12'h010, 32'h11223344, 4'b0101, 1'b0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 12'h013, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 12'hFFC, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 12'h810, 32'h99999999, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 12'h008, 32'h00000055, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0);
    idle(1);

    $display("[TB] reset on completion edge");
    applyStimulus(0, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 1'b0);
    scoreEn[0] = 1'b0;
    setWrAddr(0, 1'b1, 12'h020);
    setData(0, 32'h12345678, 4'hF);
    setCtrl(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    setCtrl(0, 1'b1, 1'b1);
    waitReady(0, 1'b0, done);
    resetA_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset mid-transfer ready", 64'(readyOf(0)), 64'd0);
    checkOutput("reset mid-transfer slv_err", 64'(errOf(0)), 64'd0);
    checkOutput("reset mid-transfer rdata", 64'(rdataOf(0)), 64'd0);
    resetA_n = 1'b1;
    setCtrl(0, 1'b0, 1'b0);
    scoreEn[0] = 1'b1;
    idle(1);
    applyStimulus(0, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0);

    $display("[TB] sel dropped during wait");
    applyStimulus(0, 1'b1, 12'h030, 32'hA5A5A5A5, 4'hF, 1'b0);
    setWrAddr(0, 1'b1, 12'h030);
    setData(0, 32'h00000000, 4'hF);
    setCtrl(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    setCtrl(0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("abort first access ready", 64'(readyOf(0)), 64'd0);
    @(posedge clk);
    #1;
    setCtrl(0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort ready", 64'(readyOf(0)), 64'd0);
      checkOutput("abort slv_err", 64'(errOf(0)), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 12'h030, 32'h0, 4'h0, 1'b0);

    $display("[TB] zero wait states back-to-back");
    applyStimulus(1, 1'b1, 12'h000, 32'h1, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 12'h004, 32'h2, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 12'h008, 32'h3, 4'hF, 1'b0);
    applyStimulus(1, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 12'h004, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 12'h00A, 32'h0, 4'h0, 1'b0);
    idle(1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 200; n++) begin
      int          unit;
      int          r;
      logic [11:0] addr;
      unit = n % 2;
      r = $urandom_range(0, 9);
      if (r < 7) addr = 12'($urandom_range(0, 15) * 4);
      else if (r == 7) addr = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else addr = 12'($urandom_range(0, 1023) * 4);
      applyStimulus(unit, 1'($urandom), addr, $urandom, 4'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(3);
    checkOutput("u0 outstanding predictions", 64'(qA.size()), 64'd0);
    checkOutput("u1 outstanding predictions", 64'(qB.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
